// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder
//   Turns the PS/2 receiver's byte stream into clean key events. The receiver
//   raises a byte-ready level (flag) in its own clock domain; that level is
//   synchronised and edge-detected here. Set-2 sequences are assembled:
//   make, break (F0), extended (E0) and the 8-byte Pause sequence (E1 ...).
//   Each completed sequence produces one single-cycle pulse.
//
// Ports
//   clock          system clock
//   reset          asynchronous active-low reset
//   Key_code[7:0]  byte from the receiver, stable while flag is high
//   flag           byte-ready level, asynchronous to clock
//   key_valid      one-cycle pulse: key event on key_code/key_extended/key_release
//   key_code[7:0]  final scan-code byte of the last event (held)
//   key_extended   last event was E0-prefixed (held)
//   key_release    last event was a break (held)
//   pause_pressed  one-cycle pulse: full Pause sequence consumed
//   seq_error      one-cycle pulse: malformed sequence or inter-byte timeout
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] Key_code,
    input  logic       flag,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_extended,
    output logic       key_release,
    output logic       pause_pressed,
    output logic       seq_error
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] EXT     = 3'd1;
    localparam logic [2:0] BRK     = 3'd2;
    localparam logic [2:0] EXT_BRK = 3'd3;
    localparam logic [2:0] PAUSE   = 3'd4;

    // Synchroniser + delay flop. All reset high so a flag that is already
    // high when reset releases does not look like a rising edge.
    logic s1, s2, s3;
    logic byte_stb;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= flag;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign byte_stb = s2 & ~s3;

    logic [2:0]    state, state_nx;
    logic [2:0]    skip_cnt, skip_nx;
    logic [CW-1:0] to_cnt;
    logic          timeout;
    logic          ev_key, ev_ext, ev_rel, ev_pause, ev_err;
    logic          is_bad;

    // Fires in the cycle whose closing edge would make the count reach
    // TIMEOUT_CYCLES, so the error pulse lands exactly that many edges
    // after the strobe that left IDLE.
    assign timeout = (state != IDLE) && (to_cnt == CW'(TIMEOUT_CYCLES - 1));
    assign is_bad  = (Key_code == 8'h00) || (Key_code == 8'hFF);

    always_comb begin
        state_nx = state;
        skip_nx  = skip_cnt;
        ev_key   = 1'b0;
        ev_ext   = 1'b0;
        ev_rel   = 1'b0;
        ev_pause = 1'b0;
        ev_err   = 1'b0;
        if (byte_stb) begin
            // A byte arriving in the timeout cycle takes priority.
            case (state)
                IDLE: begin
                    if (Key_code == 8'hE0) begin
                        state_nx = EXT;
                    end else if (Key_code == 8'hF0) begin
                        state_nx = BRK;
                    end else if (Key_code == 8'hE1) begin
                        state_nx = PAUSE;
                        skip_nx  = 3'd7;
                    end else if (is_bad) begin
                        ev_err = 1'b1;
                    end else if (Key_code == 8'hAA || Key_code == 8'hFA ||
                                 Key_code == 8'hEE) begin
                        // BAT / ACK / echo responses carry no key information
                    end else begin
                        ev_key = 1'b1;
                    end
                end
                EXT, BRK, EXT_BRK: begin
                    if (is_bad) begin
                        ev_err   = 1'b1;
                        state_nx = IDLE;
                    end else if (Key_code == 8'hE1) begin
                        // Abandon the partial sequence but still swallow Pause
                        ev_err   = 1'b1;
                        state_nx = PAUSE;
                        skip_nx  = 3'd7;
                    end else if (Key_code == 8'hF0) begin
                        if (state == EXT) begin
                            state_nx = EXT_BRK;
                        end else begin
                            ev_err   = 1'b1;
                            state_nx = IDLE;
                        end
                    end else if (Key_code == 8'hE0) begin
                        ev_err   = 1'b1;
                        state_nx = (state == BRK) ? IDLE : EXT;
                    end else begin
                        ev_key   = 1'b1;
                        ev_ext   = (state != BRK);
                        ev_rel   = (state != EXT);
                        state_nx = IDLE;
                    end
                end
                PAUSE: begin
                    skip_nx = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) begin
                        ev_pause = 1'b1;
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end else if (timeout) begin
            ev_err   = 1'b1;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            skip_cnt      <= 3'd0;
            to_cnt        <= '0;
            key_valid     <= 1'b0;
            key_code      <= 8'h00;
            key_extended  <= 1'b0;
            key_release   <= 1'b0;
            pause_pressed <= 1'b0;
            seq_error     <= 1'b0;
        end else begin
            state         <= state_nx;
            skip_cnt      <= skip_nx;
            to_cnt        <= (byte_stb || timeout || state == IDLE) ? '0 : to_cnt + CW'(1);
            key_valid     <= ev_key;
            pause_pressed <= ev_pause;
            seq_error     <= ev_err;
            if (ev_key) begin
                key_code     <= Key_code;
                key_extended <= ev_ext;
                key_release  <= ev_rel;
            end
        end
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench for ps2_scancode_decoder. Each byte sent may push an
// expected event (kind, code, ext, rel, cycle at which it must appear);
// a negedge monitor pops and compares whenever any output pulse is seen.
// Flag pulse/gap lengths are scaled down so multi-byte sequences stay well
// inside the 100-cycle timeout used here.
module tb_ps2_scancode_decoder;
    localparam int TO = 100;
    localparam int K_KEY = 0, K_PAUSE = 1, K_ERR = 2, K_NONE = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] Key_code = 8'h00;
    logic       flag = 1'b0;
    logic       key_valid, key_extended, key_release, pause_pressed, seq_error;
    logic [7:0] key_code;

    typedef struct {
        int kind;
        int code;
        int ext;
        int rel;
        int cyc;
    } ev_t;

    ev_t q[$];
    ev_t mon_e;
    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  rise;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .Key_code(Key_code), .flag(flag),
        .key_valid(key_valid), .key_code(key_code), .key_extended(key_extended),
        .key_release(key_release), .pause_pressed(pause_pressed), .seq_error(seq_error)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    // Flag rises at a negedge; it is sampled on the next posedge (edge 1)
    // and the registered event appears after edge 3.
    task automatic send(input logic [7:0] b, input int kind, input int ext,
                        input int rel, output int rise_cyc);
        @(negedge clock);
        rise_cyc = cyc;
        if (kind != K_NONE) q.push_back('{kind, int'(b), ext, rel, cyc + 3});
        Key_code = b;
        flag = 1'b1;
        repeat (10) @(negedge clock);
        flag = 1'b0;
        repeat (30) @(negedge clock);
    endtask

    always @(negedge clock) begin
        if (key_valid || pause_pressed || seq_error) begin
            check("pulse_onehot", int'(key_valid) + int'(pause_pressed) + int'(seq_error), 1);
            if (q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                mon_e = q.pop_front();
                check("evt_kind", key_valid ? K_KEY : (pause_pressed ? K_PAUSE : K_ERR), mon_e.kind);
                check("evt_cycle", cyc, mon_e.cyc);
                if (mon_e.kind == K_KEY) begin
                    check("evt_code", int'(key_code), mon_e.code);
                    check("evt_ext", int'(key_extended), mon_e.ext);
                    check("evt_rel", int'(key_release), mon_e.rel);
                end
            end
        end
    end

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, int'(key_valid), 0);
        check({tag, "_code"}, int'(key_code), 0);
        check({tag, "_ext"}, int'(key_extended), 0);
        check({tag, "_rel"}, int'(key_release), 0);
        check({tag, "_pause"}, int'(pause_pressed), 0);
        check({tag, "_err"}, int'(seq_error), 0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_outputs_zero("reset");
        reset = 1'b1;
        repeat (5) @(negedge clock);

        // make / break
        send(8'h1C, K_KEY, 0, 0, rise);
        send(8'hF0, K_NONE, 0, 0, rise);
        send(8'h1C, K_KEY, 0, 1, rise);

        // extended make / break
        send(8'hE0, K_NONE, 0, 0, rise);
        send(8'h75, K_KEY, 1, 0, rise);
        send(8'hE0, K_NONE, 0, 0, rise);
        send(8'hF0, K_NONE, 0, 0, rise);
        send(8'h75, K_KEY, 1, 1, rise);

        // Pause: only the 8th byte produces an event
        send(8'hE1, K_NONE, 0, 0, rise);
        send(8'h14, K_NONE, 0, 0, rise);
        send(8'h77, K_NONE, 0, 0, rise);
        send(8'hE1, K_NONE, 0, 0, rise);
        send(8'hF0, K_NONE, 0, 0, rise);
        send(8'h14, K_NONE, 0, 0, rise);
        send(8'hF0, K_NONE, 0, 0, rise);
        send(8'h77, K_PAUSE, 0, 0, rise);
        // event fields hold from the last key event across the pause
        check("hold_code", int'(key_code), 'h75);
        check("hold_ext", int'(key_extended), 1);
        check("hold_rel", int'(key_release), 1);
        send(8'h1C, K_KEY, 0, 0, rise);

        // E0 then silence: error exactly TO edges after the E0 is absorbed
        send(8'hE0, K_NONE, 0, 0, rise);
        q.push_back('{K_ERR, 0, 0, 0, rise + 3 + TO});
        repeat (TO) @(negedge clock);
        send(8'h29, K_KEY, 0, 0, rise);

        // double break prefix, then bad byte in IDLE
        send(8'hF0, K_NONE, 0, 0, rise);
        send(8'hF0, K_ERR, 0, 0, rise);
        send(8'h1C, K_KEY, 0, 0, rise);
        send(8'h00, K_ERR, 0, 0, rise);

        // reset mid-sequence discards the E0 prefix
        send(8'hE0, K_NONE, 0, 0, rise);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_outputs_zero("midseq_reset");
        reset = 1'b1;
        repeat (3) @(negedge clock);
        send(8'h75, K_KEY, 0, 0, rise);

        // flag held high across reset release: no byte must appear
        @(negedge clock);
        reset = 1'b0;
        Key_code = 8'h1C;
        flag = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        flag = 1'b0;
        repeat (10) @(negedge clock);
        send(8'h29, K_KEY, 0, 0, rise);

        repeat (2 * TO) @(negedge clock);
        check("events_outstanding", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumes the byte stream from the PS/2 receiver, which provides a `Key_code` byte and a `flag` strobe clocked in the PS/2 domain.
- Assembles Set-2 scan-code sequences: make, break (F0), extended (E0) and Pause (E1).
- Emits one clean single-cycle key event per sequence in the system clock domain.
- Sits between the PS/2 receiver and the game/control logic.

Parameters:
- TIMEOUT_CYCLES, 500000, system-clock cycles allowed between bytes of one multi-byte sequence before it is abandoned (10 ms at 50 MHz). Internal counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- Key_code  in  8  byte from the PS/2 receiver; stable while flag is high
- flag  in  1  byte-ready level from the PS/2 receiver; asynchronous to clock
- key_valid  out  1  one-cycle pulse: a key event is presented
- key_code  out  8  final (non-prefix) scan-code byte of the event
- key_extended  out  1  event was E0-prefixed
- key_release  out  1  event was F0-prefixed (break); 0 = make
- pause_pressed  out  1  one-cycle pulse: full 8-byte Pause sequence consumed
- seq_error  out  1  one-cycle pulse: malformed sequence or timeout

Behaviour:
- Reset (reset=0, async):
  - All outputs are 0.
  - State is IDLE and the timeout counter is 0.
  - Both flag synchroniser flops and the edge-detect delay flop reset to 1, so a flag already high at reset release produces no byte.
- Byte strobe:
  - flag passes a 2-flop synchroniser (s1, s2), then a delay flop s3.
  - byte_stb = s2 & ~s3.
  - Key_code is captured on the byte_stb cycle.
  - Outputs are registered, so key_valid rises on the 3rd clock edge after the first edge at which flag is sampled high.
- State machine (states IDLE, EXT, BRK, EXT_BRK, PAUSE); transitions occur on byte_stb:
  - IDLE:
    - E0 -> EXT.
    - F0 -> BRK.
    - E1 -> PAUSE with skip_cnt=7.
    - 00/FF -> seq_error, stay IDLE.
    - AA/FA/EE -> ignored, stay IDLE.
    - Any other byte -> key_valid, key_code=byte, ext=0, rel=0; stay IDLE.
  - EXT:
    - F0 -> EXT_BRK.
    - E0 -> seq_error, stay EXT.
    - Other byte -> key_valid, ext=1, rel=0; go IDLE.
  - BRK:
    - Plain byte -> key_valid, ext=0, rel=1; go IDLE.
    - F0 or E0 -> seq_error; go IDLE.
  - EXT_BRK:
    - Plain byte -> key_valid, ext=1, rel=1; go IDLE.
    - F0 -> seq_error; go IDLE.
    - E0 -> seq_error; go EXT.
  - PAUSE:
    - Every byte decrements skip_cnt; contents are not checked.
    - The byte that takes skip_cnt 1->0 pulses pause_pressed and goes IDLE.
    - No key_valid is generated.
  - 00/FF in any non-IDLE state -> seq_error; go IDLE.
  - E1 in EXT/BRK/EXT_BRK -> seq_error; go PAUSE with skip_cnt=7.
- Timeout:
  - The counter clears on every byte_stb and in IDLE.
  - In any other state it increments each cycle.
  - On reaching TIMEOUT_CYCLES: seq_error pulse, go IDLE, counter clears.
  - If byte_stb and the timeout coincide, the byte wins: it is processed in the current state and the counter clears.
- Output holding:
  - key_code, key_extended and key_release hold their last event values until the next key_valid.
  - key_valid, pause_pressed and seq_error are strictly one-cycle pulses and never assert together.
- Reset mid-sequence: the partial sequence is discarded and no event is emitted.

Test Plan:
- Bytes 1C, then F0 1C (each flag pulse 2 µs, gaps 100 µs) -> event 1: key_valid with key_code=1C, ext=0, rel=0; event 2: key_code=1C, ext=0, rel=1; exactly 2 key_valid pulses, each 3 edges after flag rise.
- E0 75, then E0 F0 75 -> events 75/ext=1/rel=0 and 75/ext=1/rel=1; no events for prefix bytes.
- E1 14 77 E1 F0 14 F0 77 -> exactly one pause_pressed pulse after the 8th byte; zero key_valid; a following 1C gives a normal make.
- E0, then no byte for TIMEOUT_CYCLES (set 100 in sim) -> seq_error on cycle 100 after the E0 strobe; state IDLE; next 29 gives make 29/ext=0.
- F0 F0 1C -> seq_error on the 2nd F0; 1C then reported as a make (rel=0). Also 00 in IDLE -> seq_error only.
- Assert reset between E0 and 75 -> all outputs 0; after release 75 is reported with ext=0. Hold flag high across reset release -> no spurious byte.
